// File: rtl/lcd_ctrl.sv
// HD44780-compatible character-LCD sequencer: autonomous power-on init, then
// one timed EN strobe per accepted CPU command/data write, with busy/drop status.
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned CMD_CYC   = 2500,
  parameter int unsigned LONG_CYC  = 82000,
  parameter int unsigned INIT_CYC  = 2000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_drop,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  // Zero-length phases are stretched to one cycle; values are terminal counts.
  localparam logic [31:0] SETUP_LAST = (SETUP_CYC == 0) ? 32'd0 : 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = (EN_CYC    == 0) ? 32'd0 : 32'(EN_CYC - 1);
  localparam logic [31:0] HOLD_LAST  = (HOLD_CYC  == 0) ? 32'd0 : 32'(HOLD_CYC - 1);
  localparam logic [31:0] CMD_LAST   = (CMD_CYC   == 0) ? 32'd0 : 32'(CMD_CYC - 1);
  localparam logic [31:0] LONG_LAST  = (LONG_CYC  == 0) ? 32'd0 : 32'(LONG_CYC - 1);
  localparam logic [31:0] INIT_LAST  = (INIT_CYC  == 0) ? 32'd0 : 32'(INIT_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_LOAD,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  idx;
  logic        long_item;
  logic [31:0] wait_last;
  logic        unused_wdata;

  assign unused_wdata = ^i_wdata[31:9];

  // {RS, byte} for each power-on init step.
  function automatic logic [8:0] init_item(input logic [1:0] i);
    case (i)
      2'd0:    init_item = 9'h038;
      2'd1:    init_item = 9'h00C;
      2'd2:    init_item = 9'h001;
      default: init_item = 9'h006;
    endcase
  endfunction

  // Clear/home (RS=0, 0x01..0x03) need the long execution wait.
  assign long_item = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 ||
                                   o_lcd_data == 8'h03);
  assign wait_last = long_item ? LONG_LAST : CMD_LAST;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_INIT_WAIT;
      cnt         <= 32'd0;
      idx         <= 2'd0;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
      o_drop      <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_data  <= 8'h00;
    end else begin
      o_lcd_on <= 1'b1;
      o_lcd_rw <= 1'b0;
      o_drop   <= i_wr && (state != S_IDLE);
      case (state)
        S_INIT_WAIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= 32'd0;
            idx   <= 2'd0;
            state <= S_LOAD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_LOAD: begin
          {o_lcd_rs, o_lcd_data} <= init_item(idx);
          cnt   <= 32'd0;
          state <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= 32'd0;
            o_lcd_en <= 1'b1;
            state    <= S_EN_HI;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_EN_HI: begin
          if (cnt == EN_LAST) begin
            cnt      <= 32'd0;
            o_lcd_en <= 1'b0;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= 32'd0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_last) begin
            cnt <= 32'd0;
            if (!o_init_done && idx != 2'd3) begin
              idx   <= idx + 2'd1;
              state <= S_LOAD;
            end else begin
              o_init_done <= 1'b1;
              o_busy      <= 1'b0;
              state       <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          // Host writes skip LOAD: the pins are latched on the accept edge.
          if (i_wr) begin
            o_lcd_rs   <= i_wdata[8];
            o_lcd_data <= i_wdata[7:0];
            o_busy     <= 1'b1;
            cnt        <= 32'd0;
            state      <= S_SETUP;
          end
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short phase parameters; a monitor logs EN
// pulses and busy windows, the stimulus compares them to hand-computed values.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, init_done, drop, lcd_on, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  lcd_ctrl #(
    .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2), .CMD_CYC(5), .LONG_CYC(20), .INIT_CYC(10)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_wdata(wdata),
    .o_busy(busy), .o_init_done(init_done), .o_drop(drop), .o_lcd_on(lcd_on),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Monitor state: cyc counts rising edges; sampled 1 ns after each edge.
  int         cyc = 0;
  int         rise_q[$];
  logic [7:0] data_q[$];
  logic       rs_q[$];
  int         len_q[$];
  int         last_rise = 0;
  int         busy_rise = 0;
  int         busy_len = 0;
  int         drop_cnt = 0;
  int         rw_bad = 0;
  logic       prev_en = 1'b0;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (lcd_en && !prev_en) begin
      last_rise = cyc;
      rise_q.push_back(cyc);
      data_q.push_back(lcd_data);
      rs_q.push_back(lcd_rs);
    end
    if (!lcd_en && prev_en) len_q.push_back(cyc - last_rise);
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_len = cyc - busy_rise;
    if (drop) drop_cnt++;
    if (lcd_rw) rw_bad++;
    prev_en   = lcd_en;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is on a negedge; returns on the negedge after the accept edge t.
  task automatic host_write(input logic [31:0] d, output int t);
    wr    = 1'b1;
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
    t  = cyc;
    $display("write 0x%03h issued, accept edge %0d", d[8:0], t);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_init();
    int c0, rb, lb, k;
    logic [7:0] exp_data [4];
    int         exp_rise [4];
    exp_data = '{8'h38, 8'h0C, 8'h01, 8'h06};
    exp_rise = '{13, 26, 39, 67};
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    chk("rst_lcd_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    rst = 1'b0;
    c0 = cyc;
    rb = rise_q.size();
    lb = len_q.size();
    @(negedge clk);
    chk("on_after_release", {31'd0, lcd_on}, 32'd1);
    // Write during init must be dropped without disturbing the sequence.
    wr    = 1'b1;
    wdata = 32'h155;
    @(negedge clk);
    wr = 1'b0;
    chk("init_drop", {31'd0, drop}, 32'd1);
    @(negedge clk);
    chk("init_drop_width", {31'd0, drop}, 32'd0);
    k = 0;
    while (!init_done && k < 300) begin
      chk("init_done_early", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("init_done_cycle", cyc - c0, 32'd77);
    chk("init_busy_low", {31'd0, busy}, 32'd0);
    chk("init_pulses", rise_q.size() - rb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rb + i < rise_q.size() && lb + i < len_q.size()) begin
        chk($sformatf("init%0d_data", i), {24'd0, data_q[rb+i]}, {24'd0, exp_data[i]});
        chk($sformatf("init%0d_rs", i), {31'd0, rs_q[rb+i]}, 32'd0);
        chk($sformatf("init%0d_rise", i), rise_q[rb+i] - c0, exp_rise[i]);
        chk($sformatf("init%0d_len", i), len_q[lb+i], 32'd3);
      end
    end
  endtask

  initial begin
    int t;
    int d0;
    logic [31:0] b2b [3];
    b2b = '{32'h148, 32'h169, 32'h0C0};

    run_init();

    // Data 'A'.
    host_write(32'h141, t);
    chk("A_rs", {31'd0, lcd_rs}, 32'd1);
    chk("A_data", {24'd0, lcd_data}, 32'h41);
    chk("A_busy", {31'd0, busy}, 32'd1);
    chk("A_en_low", {31'd0, lcd_en}, 32'd0);
    wait_idle(100);
    chk("A_en_rise", rise_q[$] - t, 32'd2);
    chk("A_en_len", len_q[$], 32'd3);
    chk("A_busy_len", busy_len, 32'd12);

    // Clear with a rejected write mid-transfer.
    host_write(32'h001, t);
    repeat (4) @(negedge clk);
    wr    = 1'b1;
    wdata = 32'h1FF;
    @(negedge clk);
    wr = 1'b0;
    chk("mid_drop", {31'd0, drop}, 32'd1);
    chk("mid_data_kept", {24'd0, lcd_data}, 32'h01);
    chk("mid_rs_kept", {31'd0, lcd_rs}, 32'd0);
    @(negedge clk);
    chk("mid_drop_width", {31'd0, drop}, 32'd0);
    wait_idle(100);
    chk("clr_busy_len", busy_len, 32'd27);
    chk("clr_en_len", len_q[$], 32'd3);

    // 0x80, plus a write landing on the edge busy falls.
    host_write(32'h080, t);
    repeat (11) @(negedge clk);
    chk("edge_busy_before", {31'd0, busy}, 32'd1);
    wr    = 1'b1;
    wdata = 32'h1AA;
    @(negedge clk);
    wr = 1'b0;
    chk("edge_drop", {31'd0, drop}, 32'd1);
    chk("edge_busy_fell", {31'd0, busy}, 32'd0);
    chk("edge_data_kept", {24'd0, lcd_data}, 32'h80);
    chk("cmd80_busy_len", busy_len, 32'd12);
    @(negedge clk);
    chk("edge_not_accepted", {31'd0, busy}, 32'd0);

    // Back-to-back writes, each on the first idle cycle.
    d0 = drop_cnt;
    foreach (b2b[i]) begin
      host_write(b2b[i], t);
      wait_idle(100);
      chk($sformatf("b2b%0d_busy_len", i), busy_len, 32'd12);
      chk($sformatf("b2b%0d_data", i), {24'd0, data_q[$]}, {24'd0, b2b[i][7:0]});
      chk($sformatf("b2b%0d_rs", i), {31'd0, rs_q[$]}, {31'd0, b2b[i][8]});
    end
    chk("b2b_no_drop", drop_cnt - d0, 32'd0);
    chk("rw_always_low", rw_bad, 32'd0);

    // Asynchronous reset while EN is high.
    host_write(32'h148, t);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_en", {31'd0, lcd_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_en", {31'd0, lcd_en}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd1);
    chk("async_lcd_on", {31'd0, lcd_on}, 32'd0);
    chk("async_data", {24'd0, lcd_data}, 32'd0);
    chk("async_init_done", {31'd0, init_done}, 32'd0);
    run_init();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware HD44780-compatible character-LCD sequencer that sits behind the LCD I/O register of the single-cycle core's LSU. It consumes one-word command/data writes from the CPU side and produces correctly timed RS/RW/EN/DATA pin activity. It runs the power-on initialisation sequence autonomously, and it exposes busy/ready status that software polls before issuing the next write.

## Interface

Parameters (defaults for 50 MHz):
- SETUP_CYC, 4: cycles RS/DATA are stable with EN low before EN rises (≥40 ns)
- EN_CYC, 25: cycles EN is held high (≥450 ns)
- HOLD_CYC, 4: cycles RS/DATA are held after EN falls
- CMD_CYC, 2500: post-hold wait for ordinary commands and data (≥37 µs)
- LONG_CYC, 82000: post-hold wait for clear/home, i.e. RS=0 and data 0x01, 0x02 or 0x03 (≥1.52 ms)
- INIT_CYC, 2000000: power-on wait before the first init command (≥40 ms)

Ports:
- i_clk  in  1  single clock; all state on its rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr  in  1  write strobe, one cycle per request
- i_wdata  in  32  [8]=RS (0 command, 1 data), [7:0]=byte; other bits ignored
- o_busy  out  1  high while initialising or while a transfer or its wait is in progress
- o_init_done  out  1  high once the init sequence completes; stays high until reset
- o_drop  out  1  one-cycle pulse when a write is rejected
- o_lcd_on  out  1  LCD power/backlight enable
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD read/write; constant 0 (write-only)
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_data  out  8  LCD data bus

## Operation

- All outputs are registered. Reset values: o_busy=1, o_init_done=0, o_drop=0, o_lcd_on=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_data=0x00.
- States:
  - INIT_WAIT: o_lcd_on=1 from the first edge after reset release. Count INIT_CYC cycles, then go to LOAD with init index 0.
  - LOAD: drive o_lcd_rs and o_lcd_data with the current item, then go to SETUP.
  - SETUP: EN=0 for SETUP_CYC cycles, then go to EN_HI.
  - EN_HI: EN=1 for EN_CYC cycles, then go to HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles, then go to WAIT.
  - WAIT: count LONG_CYC if the item is clear/home, otherwise CMD_CYC. On exit:
    - if init items remain, go to LOAD;
    - otherwise go to IDLE.
  - IDLE: o_busy=0.
- Init sequence, all RS=0: 0x38 (8-bit, 2 lines, 5x8), then 0x0C (display on), then 0x01 (clear, long wait), then 0x06 (entry mode increment). o_init_done rises on the WAIT-exit edge of the last item.
- Host write acceptance:
  - A write is accepted when i_wr=1 in IDLE. On that edge the controller latches i_wdata[8] into o_lcd_rs and i_wdata[7:0] into o_lcd_data, sets o_busy=1 and enters SETUP; LOAD is skipped.
  - i_wr=1 in any other state is ignored, and o_drop=1 on the following cycle. LCD pins and state are unchanged.
  - If i_wr arrives on the same edge o_busy falls, the write is rejected, because acceptance depends on the registered state being IDLE.
- RS/DATA are held from LOAD/accept through the end of WAIT; they change only at the next LOAD or accept.
- Counters are at least 32 bits wide, or clog2 of the largest parameter. Each phase lasts exactly its parameter count; a parameter of 0 is treated as 1.
- An asynchronous reset mid-transfer forces EN low immediately, with all outputs at their reset values. Init restarts from INIT_WAIT after release.

## Timing

- Accepted host write, measured from the accept edge T:
  - EN rises at T+SETUP_CYC
  - EN falls at T+SETUP_CYC+EN_CYC
  - o_busy falls at T+SETUP_CYC+EN_CYC+HOLD_CYC+wait
- Best-case write throughput is one transfer per SETUP+EN+HOLD+wait+1 cycles; the +1 is the IDLE accept cycle.
- Init duration is INIT_CYC + 4·(1+SETUP+EN+HOLD) + 3·CMD_CYC + LONG_CYC cycles. LOAD counts as one cycle.
- o_drop latency is 1 cycle; the pulse width is 1 cycle per rejected write.

## Test plan

All scenarios use SETUP=2, EN=3, HOLD=2, CMD=5, LONG=20, INIT=10.
- Reset then release:
  - All outputs match their reset values during reset; o_lcd_on=1 one cycle after release.
  - EN pulses 4 times, each 3 cycles high, with data 0x38, 0x0C, 0x01, 0x06 and RS=0.
  - The gap after 0x01 reflects the 20-cycle wait; o_init_done and !o_busy assert at cycle 10+4·8+15+20=77.
- After init, write i_wdata=0x141 ('A', RS=1):
  - RS=1 and data=0x41 appear on the next edge; EN is high for cycles 2–4 after accept.
  - o_busy is high for exactly 12 cycles.
- Write 0x001 (clear) -> o_busy is high for 27 cycles. Write 0x080 -> o_busy is high for 12 cycles.
- Issue i_wr during busy, both during init and mid-transfer -> o_drop pulses for 1 cycle each time; pins and busy duration are unaffected. Issue i_wr on the edge o_busy falls -> rejected with o_drop.
- Assert i_reset while EN is high -> EN=0 asynchronously, before the next clock edge. After release the full init sequence repeats and o_init_done=0 until complete.
- Back-to-back writes, each issued on the first cycle o_busy=0 -> every write is accepted, no o_drop, and o_lcd_rw=0 throughout.
